// File: rtl/mem_string_writer.sv
// Byte-stream to null-terminated string writer for the syscall read_string path.
// Optional MEM_STRING_ECHO_EN build macro echoes accepted characters to the simulator console.
module mem_string_writer #(
    parameter logic [7:0] NL_CHAR = 8'h0A,
    parameter int          ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       max_len,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       str_len
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        TERM,
        WRITE_T,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_base;
    logic [31:0]         r_maxLen;
    logic [31:0]         r_count;
    logic [ADDR_W-3:0]   r_wordIdx;
    logic [31:0]         r_wordBuf;
    logic                r_termPending;
    logic [31:0]         r_strLen;

    logic                w_accept;
    logic [1:0]          w_lane;
    logic                w_isLast;
    logic [ADDR_W-1:0]   w_wordOffset;

    assign w_accept     = char_valid && (r_state == COLLECT);
    assign w_lane       = r_count[1:0];
    assign w_isLast     = (char_data == NL_CHAR) || ((r_count + 32'd1) == (r_maxLen - 32'd1));
    assign w_wordOffset = {r_wordIdx, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A terminating char that also fills lane 3 must flush its word before the null word.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (max_len == 32'd0) begin
                        w_nextState = DONE;
                    end else if (max_len == 32'd1) begin
                        w_nextState = TERM;
                    end else begin
                        w_nextState = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    if (w_lane == 2'd3) begin
                        w_nextState = WRITE;
                    end else if (w_isLast) begin
                        w_nextState = TERM;
                    end
                end
            end
            WRITE:   w_nextState = r_termPending ? TERM : COLLECT;
            TERM:    w_nextState = WRITE_T;
            WRITE_T: w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The buffer is zeroed after every write, so at TERM the null lane and all higher lanes are already 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base        <= '0;
            r_maxLen      <= '0;
            r_count       <= '0;
            r_wordIdx     <= '0;
            r_wordBuf     <= '0;
            r_termPending <= 1'b0;
            r_strLen      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base        <= base_addr;
                        r_maxLen      <= max_len;
                        r_count       <= '0;
                        r_wordIdx     <= '0;
                        r_wordBuf     <= '0;
                        r_termPending <= 1'b0;
                        r_strLen      <= '0;
                    end
                end
                COLLECT: begin
                    if (w_accept) begin
                        r_wordBuf[{w_lane, 3'b000} +: 8] <= char_data;
                        r_count                          <= r_count + 32'd1;
                        if (w_lane == 2'd3) begin
                            r_termPending <= w_isLast;
                        end
                    end
                end
                WRITE, WRITE_T: begin
                    r_wordIdx <= r_wordIdx + (ADDR_W-2)'(1);
                    r_wordBuf <= '0;
                end
                TERM: begin
                    r_strLen <= r_count;
                end
                default: begin
                end
            endcase
        end
    end

    assign char_ready = (r_state == COLLECT);
    assign mem_write  = (r_state == WRITE) || (r_state == WRITE_T);
    assign mem_addr   = mem_write ? ((r_base + w_wordOffset) & ~ADDR_W'(3)) : '0;
    assign mem_wdata  = mem_write ? r_wordBuf : '0;
    assign busy       = (r_state != IDLE) && (r_state != DONE);
    assign done       = (r_state == DONE);
    assign str_len    = r_strLen;

`ifdef MEM_STRING_ECHO_EN
    always @(posedge clk) begin
        if (!rst && w_accept) begin
            $write("%c", char_data);
        end
        if (!rst && r_state == DONE) begin
            $write("\n");
        end
    end
`else
    // Echo disabled: the engine produces no console output.
`endif

endmodule

// File: tb/tb_mem_string_writer.sv
// Directed self-checking bench for mem_string_writer: packing, termination, handshake and reset abort.
module tb_mem_string_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] max_len;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [31:0] str_len;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    int          doneCount = 0;
    logic [31:0] lenAtDone = '0;

    mem_string_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .max_len    (max_len),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .str_len    (str_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_write) begin
                wrAddrQ.push_back(mem_addr);
                wrDataQ.push_back(mem_wdata);
            end
            if (done) begin
                doneCount = doneCount + 1;
                lenAtDone = str_len;
            end
        end
    end

    task automatic startPulse(input logic [31:0] base, input logic [31:0] maxLen);
        wrAddrQ.delete();
        wrDataQ.delete();
        base_addr = base;
        max_len   = maxLen;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic sendChars(input string s, output int accepted);
        int waited;
        accepted   = 0;
        char_valid = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            char_data = s[i];
            waited = 0;
            while (!char_ready && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            if (!char_ready) break;
            @(negedge clk);
            accepted++;
        end
        char_valid = 1'b0;
        char_data  = 8'h00;
    endtask

    task automatic waitDone(input int doneBefore);
        int waited = 0;
        while (doneCount == doneBefore && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (doneCount == doneBefore) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: done count %0d, required %0d", doneCount, doneBefore + 1);
        end
        @(negedge clk);
    endtask

    task automatic runString(input logic [31:0] base, input logic [31:0] maxLen,
                             input string s, output int accepted);
        int doneBefore;
        doneBefore = doneCount;
        startPulse(base, maxLen);
        sendChars(s, accepted);
        waitDone(doneBefore);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({char_ready, mem_write, busy, done} !== 4'b0000 || str_len !== 32'd0 || mem_addr !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got ready/wr/busy/done=%b len=%0d addr=%h, required 0000/0/0",
                     {char_ready, mem_write, busy, done}, str_len, mem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({char_ready, mem_write, busy, done} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL idle_outputs: got %b, required 0000", {char_ready, mem_write, busy, done});
        end
    endtask

    task automatic test_short_string;
        int acc;
        runString(32'h1000, 32'd16, "hi\n", acc);
        vectors++;
        if (wrAddrQ.size() !== 1) begin
            miscompares++;
            $display("[TB] FAIL hi_write_count: got %0d, required 1", wrAddrQ.size());
        end else if (wrAddrQ[0] !== 32'h1000 || wrDataQ[0] !== 32'h000A6968) begin
            miscompares++;
            $display("[TB] FAIL hi_word: got %h@%h, required 000a6968@00001000", wrDataQ[0], wrAddrQ[0]);
        end
        vectors++;
        if (lenAtDone !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL hi_len: got %0d, required 3", lenAtDone);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (str_len !== 32'd3 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hi_len_held: got len %0d busy %b, required 3 0", str_len, busy);
        end
    endtask

    task automatic test_two_words;
        int acc;
        runString(32'h1000, 32'd16, "abcd\n", acc);
        vectors++;
        if (wrAddrQ.size() !== 2) begin
            miscompares++;
            $display("[TB] FAIL abcd_write_count: got %0d, required 2", wrAddrQ.size());
        end else if (wrAddrQ[0] !== 32'h1000 || wrDataQ[0] !== 32'h64636261 ||
                     wrAddrQ[1] !== 32'h1004 || wrDataQ[1] !== 32'h0000000A) begin
            miscompares++;
            $display("[TB] FAIL abcd_words: got %h@%h %h@%h, required 64636261@00001000 0000000a@00001004",
                     wrDataQ[0], wrAddrQ[0], wrDataQ[1], wrAddrQ[1]);
        end
        vectors++;
        if (lenAtDone !== 32'd5) begin
            miscompares++;
            $display("[TB] FAIL abcd_len: got %0d, required 5", lenAtDone);
        end
    endtask

    task automatic test_nl_in_lane3;
        int acc;
        runString(32'h4000, 32'd16, "abc\n", acc);
        vectors++;
        if (wrAddrQ.size() !== 2) begin
            miscompares++;
            $display("[TB] FAIL nl3_write_count: got %0d, required 2", wrAddrQ.size());
        end else if (wrAddrQ[0] !== 32'h4000 || wrDataQ[0] !== 32'h0A636261 ||
                     wrAddrQ[1] !== 32'h4004 || wrDataQ[1] !== 32'h00000000) begin
            miscompares++;
            $display("[TB] FAIL nl3_words: got %h@%h %h@%h, required 0a636261@00004000 00000000@00004004",
                     wrDataQ[0], wrAddrQ[0], wrDataQ[1], wrAddrQ[1]);
        end
        vectors++;
        if (lenAtDone !== 32'd4) begin
            miscompares++;
            $display("[TB] FAIL nl3_len: got %0d, required 4", lenAtDone);
        end
    endtask

    task automatic test_max_len_limit;
        int acc;
        runString(32'h1000, 32'd5, "abcdefg", acc);
        vectors++;
        if (acc !== 4) begin
            miscompares++;
            $display("[TB] FAIL max5_accepted: got %0d, required 4", acc);
        end
        vectors++;
        if (wrAddrQ.size() !== 2) begin
            miscompares++;
            $display("[TB] FAIL max5_write_count: got %0d, required 2", wrAddrQ.size());
        end else if (wrAddrQ[0] !== 32'h1000 || wrDataQ[0] !== 32'h64636261 ||
                     wrAddrQ[1] !== 32'h1004 || wrDataQ[1] !== 32'h00000000) begin
            miscompares++;
            $display("[TB] FAIL max5_words: got %h@%h %h@%h, required 64636261@00001000 00000000@00001004",
                     wrDataQ[0], wrAddrQ[0], wrDataQ[1], wrAddrQ[1]);
        end
        vectors++;
        if (lenAtDone !== 32'd4) begin
            miscompares++;
            $display("[TB] FAIL max5_len: got %0d, required 4", lenAtDone);
        end
        runString(32'h5000, 32'd2, "xyz", acc);
        vectors++;
        if (acc !== 1 || wrAddrQ.size() !== 1 || lenAtDone !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL max2: got acc %0d writes %0d len %0d, required 1 1 1", acc, wrAddrQ.size(), lenAtDone);
        end else if (wrAddrQ[0] !== 32'h5000 || wrDataQ[0] !== 32'h00000078) begin
            miscompares++;
            $display("[TB] FAIL max2_word: got %h@%h, required 00000078@00005000", wrDataQ[0], wrAddrQ[0]);
        end
    endtask

    task automatic test_tiny_buffers;
        int acc;
        int doneBefore;
        doneBefore = doneCount;
        startPulse(32'h1000, 32'd0);
        vectors++;
        if (done !== 1'b1 || mem_write !== 1'b0 || str_len !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL max0_done: got done %b wr %b len %0d, required 1 0 0", done, mem_write, str_len);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || wrAddrQ.size() !== 0 || doneCount !== doneBefore + 1) begin
            miscompares++;
            $display("[TB] FAIL max0_after: got done %b writes %0d dones %0d, required 0 0 %0d",
                     done, wrAddrQ.size(), doneCount, doneBefore + 1);
        end
        runString(32'h3001, 32'd1, "q", acc);
        vectors++;
        if (acc !== 0 || wrAddrQ.size() !== 1 || lenAtDone !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL max1: got acc %0d writes %0d len %0d, required 0 1 0", acc, wrAddrQ.size(), lenAtDone);
        end else if (wrAddrQ[0] !== 32'h3000 || wrDataQ[0] !== 32'h00000000) begin
            miscompares++;
            $display("[TB] FAIL max1_word: got %h@%h, required 00000000@00003000", wrDataQ[0], wrAddrQ[0]);
        end
    endtask

    task automatic test_back_to_back;
        int acc;
        int doneBefore;
        doneBefore = doneCount;
        startPulse(32'h2000, 32'd16);
        vectors++;
        if (busy !== 1'b1 || char_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_busy: got busy %b ready %b, required 1 1", busy, char_ready);
        end
        sendChars("abcd", acc);
        char_valid = 1'b1;
        char_data  = "e";
        vectors++;
        if (char_ready !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'h64636261) begin
            miscompares++;
            $display("[TB] FAIL b2b_write_cycle: got ready %b wr %b %h@%h, required 0 1 64636261@00002000",
                     char_ready, mem_write, mem_wdata, mem_addr);
        end
        @(negedge clk);
        vectors++;
        if (char_ready !== 1'b1 || mem_write !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_resume: got ready %b wr %b, required 1 0", char_ready, mem_write);
        end
        sendChars("e\n", acc);
        waitDone(doneBefore);
        vectors++;
        if (wrAddrQ.size() !== 2 || lenAtDone !== 32'd6) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got writes %0d len %0d, required 2 6", wrAddrQ.size(), lenAtDone);
        end else if (wrAddrQ[1] !== 32'h2004 || wrDataQ[1] !== 32'h00000A65) begin
            miscompares++;
            $display("[TB] FAIL b2b_word2: got %h@%h, required 00000a65@00002004", wrDataQ[1], wrAddrQ[1]);
        end
    endtask

    task automatic test_reset_abort;
        int acc;
        startPulse(32'h6000, 32'd16);
        sendChars("ab", acc);
        rst = 1'b1;
        #1;
        vectors++;
        if ({char_ready, mem_write, busy, done} !== 4'b0000 || str_len !== 32'd0 || mem_wdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: got %b len %0d data %h, required 0000 0 0",
                     {char_ready, mem_write, busy, done}, str_len, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (wrAddrQ.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_write: got %0d writes, required 0", wrAddrQ.size());
        end
        runString(32'h6000, 32'd16, "hi\n", acc);
        vectors++;
        if (wrAddrQ.size() !== 1 || lenAtDone !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL abort_restart: got writes %0d len %0d, required 1 3", wrAddrQ.size(), lenAtDone);
        end else if (wrAddrQ[0] !== 32'h6000 || wrDataQ[0] !== 32'h000A6968) begin
            miscompares++;
            $display("[TB] FAIL abort_restart_word: got %h@%h, required 000a6968@00006000", wrDataQ[0], wrAddrQ[0]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        max_len    = '0;
        char_valid = 1'b0;
        char_data  = '0;
        @(negedge clk);
        test_reset();
        test_short_string();
        test_two_words();
        test_nl_in_lane3();
        test_max_len_limit();
        test_tiny_buffers();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
